// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the two-requester RAM arbiter.
//   state_e : arbiter FSM state (IDLE, OWN0 = requester 0 owns a burst,
//             OWN1 = requester 1 owns a burst)
//   REQ0/REQ1 : requester identifiers, also the encoding of the prio pointer
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick.
//   req0, req1 : pending requests
//   prio       : requester that wins when both request (REQ0/REQ1)
//   gnt        : one-hot grant, bit 0 = requester 0, bit 1 = requester 1;
//                all zero when nothing requests
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) begin
      gnt = (prio == REQ1) ? 2'b10 : 2'b01;
    end else if (req0) begin
      gnt = 2'b01;
    end else if (req1) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/ram_arbiter2.sv
// ram_arbiter2: round-robin arbiter and sequencer in front of a single-port
// RAM, with optional locked bursts of up to max_burst beats.
//
// Handshake: a requester holds reqX (with weX/lockX/addrX/wdataX stable)
// until gntX is seen high in the same cycle; gntX is combinational and means
// the beat is issued to the RAM this cycle. A granted read returns one cycle
// later with rvalidX = 1 and rdataX = ram_q for exactly that cycle.
//
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   req*/we*/lock*/addr*/wdata* : per-requester access request
//   gnt0, gnt1            : combinational beat-accepted strobes
//   rvalid0/1, rdata0/1   : registered read-return, rdata is 0 when not valid
//   ram_data/addr/en, ram_q : RAM port (en = 1 writes)
//   dbg_state             : current FSM state for observation
module ram_arbiter2
  import ram_arb_pkg::*;
#(
  parameter int addr_width = 6,
  parameter int data_width = 8,
  parameter int max_burst  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [addr_width-1:0] addr0,
  input  logic [addr_width-1:0] addr1,
  input  logic [data_width-1:0] wdata0,
  input  logic [data_width-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [data_width-1:0] rdata0,
  output logic [data_width-1:0] rdata1,
  output logic [data_width-1:0] ram_data,
  output logic [addr_width-1:0] ram_addr,
  output logic                  ram_en,
  input  logic [data_width-1:0] ram_q,
  output logic [1:0]            dbg_state
);

  localparam int cnt_w = $clog2(max_burst + 1);
  localparam logic [cnt_w-1:0] cnt_one   = cnt_w'(1);
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(max_burst - 1);
  localparam logic             can_lock  = (max_burst > 1);

  state_e           state, state_nxt;
  logic             prio, prio_nxt;
  logic [cnt_w-1:0] cnt, cnt_nxt;
  logic [1:0]       pick;
  logic [1:0]       gnt_raw;

  rr_pick2 u_pick (
    .req0 (req0),
    .req1 (req1),
    .prio (prio),
    .gnt  (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= REQ0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt holds the number of beats already taken by the owner, so the beat
  // that arrives while cnt == max_burst-1 is the last one of the burst.
  always_comb begin
    gnt_raw   = 2'b00;
    state_nxt = state;
    prio_nxt  = prio;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        gnt_raw = pick;
        if (pick[0]) begin
          prio_nxt = REQ1;
          if (lock0 && can_lock) begin
            state_nxt = OWN0;
            cnt_nxt   = cnt_one;
          end
        end else if (pick[1]) begin
          prio_nxt = REQ0;
          if (lock1 && can_lock) begin
            state_nxt = OWN1;
            cnt_nxt   = cnt_one;
          end
        end
      end
      OWN0: begin
        // The other requester is ignored; an unlocked beat may still be
        // granted and closes the burst at this edge.
        gnt_raw = {1'b0, req0};
        if (!lock0 || (req0 && cnt == last_beat)) begin
          state_nxt = IDLE;
          prio_nxt  = REQ1;
          cnt_nxt   = '0;
        end else if (req0) begin
          cnt_nxt = cnt + cnt_one;
        end
      end
      OWN1: begin
        gnt_raw = {req1, 1'b0};
        if (!lock1 || (req1 && cnt == last_beat)) begin
          state_nxt = IDLE;
          prio_nxt  = REQ0;
          cnt_nxt   = '0;
        end else if (req1) begin
          cnt_nxt = cnt + cnt_one;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Grants are forced low while reset is asserted so no RAM write can slip
  // through during reset.
  assign gnt0 = gnt_raw[0] & rst_n;
  assign gnt1 = gnt_raw[1] & rst_n;

  assign ram_addr = gnt1 ? addr1  : addr0;
  assign ram_data = gnt1 ? wdata1 : wdata0;
  assign ram_en   = (gnt0 & we0) | (gnt1 & we1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
    end
  end

  assign rdata0 = rvalid0 ? ram_q : '0;
  assign rdata1 = rvalid1 ? ram_q : '0;

  assign dbg_state = state;

endmodule

// File: tb/tb_ram_arbiter2.sv
// tb_ram_arbiter2: bench for ram_arbiter2 with a behavioural RAM attached.
module tb_ram_arbiter2;
  import ram_arb_pkg::*;

  localparam int AW   = 6;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_en;
  logic [DW-1:0] rdata0, rdata1, ram_data, ram_q;
  logic [AW-1:0] ram_addr;
  logic [1:0]    dbg_state;

  ram_arbiter2 #(.addr_width(AW), .data_width(DW), .max_burst(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_en(ram_en), .ram_q(ram_q),
    .dbg_state(dbg_state)
  );

  // Single-port RAM: write on en, read address registered.
  logic [DW-1:0] ram_mem [64];
  logic [AW-1:0] ram_areg = '0;
  always @(posedge clk) begin
    if (ram_en) ram_mem[ram_addr] <= ram_data;
    ram_areg <= ram_addr;
  end
  assign ram_q = ram_mem[ram_areg];

  // ---------------- reference model and scoreboard ----------------
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] mdl_mem [64];
  int            owner = -1;   // -1 = nobody owns a burst
  int            beats = 0;
  int            mprio = 0;
  int            last_g = -1;
  logic [8:0]    exp_q[$];     // {requester, expected read data}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    beats = 0;
    mprio = 0;
    exp_q.delete();
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Called at posedge+1; drives, checks at negedge, advances the model,
  // returns at the next posedge+1.
  task automatic cycle(input logic r0, input logic r1, input logic w0, input logic w1,
                       input logic l0, input logic l1,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    int         g;
    logic [8:0] e;
    logic       ev0, ev1, gl, gw;
    logic [DW-1:0] ed0, ed1;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    req0 = r0; req1 = r1; we0 = w0; we1 = w1; lock0 = l0; lock1 = l1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    @(negedge clk);
    if (owner < 0) begin
      if (r0 && r1) g = mprio;
      else if (r0)  g = 0;
      else if (r1)  g = 1;
      else          g = -1;
    end else begin
      g = ((owner == 0) ? r0 : r1) ? owner : -1;
    end
    gw = (g == 1) ? w1 : w0;
    gl = (g == 1) ? l1 : l0;
    ga = (g == 1) ? a1 : a0;
    gd = (g == 1) ? d1 : d0;
    chk("gnt0", gnt0, g == 0);
    chk("gnt1", gnt1, g == 1);
    chk("ram_en", ram_en, (g >= 0) && gw);
    if (g >= 0) chk("ram_addr", ram_addr, ga);
    ev0 = 0; ev1 = 0; ed0 = '0; ed1 = '0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e[8]) begin ev1 = 1; ed1 = e[7:0]; end
      else      begin ev0 = 1; ed0 = e[7:0]; end
    end
    chk("rvalid0", rvalid0, ev0);
    chk("rvalid1", rvalid1, ev1);
    chk("rdata0", rdata0, ed0);
    chk("rdata1", rdata1, ed1);
    last_g = g;
    // advance the model across the coming edge
    if (g >= 0) begin
      if (gw) mdl_mem[ga] = gd;
      else    exp_q.push_back({(g == 1), mdl_mem[ga]});
    end
    if (owner < 0) begin
      if (g >= 0) begin
        mprio = 1 - g;
        if (gl && MAXB > 1) begin owner = g; beats = 1; end
      end
    end else begin
      if (g == owner) beats++;
      if (!((owner == 0) ? l0 : l1) || beats == MAXB) begin
        mprio = 1 - owner;
        owner = -1;
        beats = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic r0, r1, w0, w1, l0, l1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    int   eg;  // expected granted requester, -1 = none
  } vec_t;

  vec_t vt[$];

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram_mem[i] = DW'(i * 7 + 3);
      mdl_mem[i] = DW'(i * 7 + 3);
    end

    // Reset with both requesting: everything low.
    req0 = 1; req1 = 1; we0 = 1; we1 = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", {gnt0, gnt1}, 2'b00);
    chk("rst_rvalid", {rvalid0, rvalid1}, 2'b00);
    chk("rst_rdata", {rdata0, rdata1}, 16'h0);
    chk("rst_ram_en", ram_en, 1'b0);
    chk("rst_state", dbg_state, IDLE);
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();

    //          r0 r1 w0 w1 l0 l1 a0     a1     d0     d1     eg
    vt.push_back('{1, 1, 0, 0, 0, 0, 6'h01, 6'h02, 8'h00, 8'h00, 0}); // first contention -> 0
    vt.push_back('{1, 0, 1, 0, 0, 0, 6'h10, 6'h00, 8'hA5, 8'h00, 0}); // write A5 @10
    vt.push_back('{1, 0, 0, 0, 0, 0, 6'h10, 6'h00, 8'h00, 8'h00, 0}); // read @10
    vt.push_back('{0, 0, 0, 0, 0, 0, 6'h00, 6'h00, 8'h00, 8'h00, -1}); // A5 returns
    vt.push_back('{1, 1, 0, 0, 0, 0, 6'h03, 6'h04, 8'h00, 8'h00, 1}); // alternation
    vt.push_back('{1, 1, 0, 0, 0, 0, 6'h05, 6'h06, 8'h00, 8'h00, 0});
    vt.push_back('{1, 1, 0, 0, 0, 0, 6'h07, 6'h08, 8'h00, 8'h00, 1});
    vt.push_back('{1, 1, 0, 0, 0, 0, 6'h09, 6'h0A, 8'h00, 8'h00, 0});
    vt.push_back('{0, 1, 0, 1, 0, 0, 6'h00, 6'h20, 8'h00, 8'h3C, 1}); // prio back to 0
    vt.push_back('{1, 1, 1, 0, 1, 0, 6'h21, 6'h20, 8'h11, 8'h00, 0}); // locked burst 4 beats
    vt.push_back('{1, 1, 1, 0, 1, 0, 6'h22, 6'h20, 8'h22, 8'h00, 0});
    vt.push_back('{1, 1, 1, 0, 1, 0, 6'h23, 6'h20, 8'h33, 8'h00, 0});
    vt.push_back('{1, 1, 1, 0, 1, 0, 6'h24, 6'h20, 8'h44, 8'h00, 0});
    vt.push_back('{1, 1, 0, 0, 1, 0, 6'h21, 6'h20, 8'h00, 8'h00, 1}); // then req1 reads 3C
    vt.push_back('{1, 1, 0, 0, 1, 0, 6'h22, 6'h21, 8'h00, 8'h00, 0}); // early unlock: 2 beats
    vt.push_back('{1, 1, 0, 0, 1, 0, 6'h23, 6'h21, 8'h00, 8'h00, 0});
    vt.push_back('{0, 1, 0, 0, 0, 0, 6'h00, 6'h21, 8'h00, 8'h00, -1}); // exit edge, no grant
    vt.push_back('{0, 1, 0, 0, 0, 0, 6'h00, 6'h21, 8'h00, 8'h00, 1});
    vt.push_back('{0, 0, 0, 0, 0, 0, 6'h00, 6'h00, 8'h00, 8'h00, -1});

    foreach (vt[i]) begin
      cycle(vt[i].r0, vt[i].r1, vt[i].w0, vt[i].w1, vt[i].l0, vt[i].l1,
            vt[i].a0, vt[i].a1, vt[i].d0, vt[i].d1);
      chk($sformatf("vec%0d_gnt", i), 32'(last_g), 32'(vt[i].eg));
    end

    // Reset mid-burst with a read in flight.
    cycle(1, 1, 0, 0, 1, 0, 6'h10, 6'h11, 8'h00, 8'h00);  // locked read, enters OWN0
    chk("burst_enter", dbg_state, OWN0);
    req0 = 1; req1 = 1; we0 = 0; lock0 = 1; addr0 = 6'h12;
    @(negedge clk);
    chk("midrd_gnt0", gnt0, 1'b1);
    chk("midrd_rvalid0", rvalid0, 1'b1);
    rst_n = 0;
    #1;
    chk("midrd_rst_rvalid0", rvalid0, 1'b0);
    chk("midrd_rst_state", dbg_state, IDLE);
    chk("midrd_rst_gnt", {gnt0, gnt1}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk("post_rst_rvalid", {rvalid0, rvalid1}, 2'b00);
    @(posedge clk); #1;
    cycle(1, 1, 0, 0, 0, 0, 6'h01, 6'h02, 8'h00, 8'h00);
    chk("post_rst_first_gnt", 32'(last_g), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            DW'($urandom), DW'($urandom));
    end
    cycle(0, 0, 0, 0, 0, 0, 6'h00, 6'h00, 8'h00, 8'h00);
    cycle(0, 0, 0, 0, 0, 0, 6'h00, 6'h00, 8'h00, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_arbiter2.md
# ram_arbiter2

Two-requester arbiter and sequencer for the single-port RAM (one access per cycle, write when `en`=1, read address registered, read data valid the following cycle). Sits between two client blocks and the RAM port. Each cycle it selects at most one request using round-robin priority, with optional locked bursts bounded by `max_burst`. It drives the RAM's `data`/`addr`/`en` and returns read data to the owning requester with a registered valid.

## Interface
Parameters:
- `addr_width`, 6, RAM address width
- `data_width`, 8, RAM data width
- `max_burst`, 4, max consecutive locked beats for one requester (≥1)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req0`, `req1`  in  1  access request; held until granted
- `we0`, `we1`  in  1  1 = write, 0 = read
- `lock0`, `lock1`  in  1  request burst ownership with this beat
- `addr0`, `addr1`  in  addr_width  access address
- `wdata0`, `wdata1`  in  data_width  write data
- `gnt0`, `gnt1`  out  1  combinational; beat accepted this cycle
- `rvalid0`, `rvalid1`  out  1  registered; read data valid
- `rdata0`, `rdata1`  out  data_width  `ram_q` when matching `rvalid` = 1, else 0
- `ram_data`  out  data_width  to RAM `data`
- `ram_addr`  out  addr_width  to RAM `addr`
- `ram_en`  out  1  to RAM `en` (1 = write)
- `ram_q`  in  data_width  from RAM `q`

## Operation
- Per cycle, at most one grant. `gnt_x` = 1 means the beat of requester x is issued to the RAM this cycle.
- `ram_addr`/`ram_data` mux the granted requester's inputs. With no grant, they hold requester 0's inputs. `ram_en = gnt & we`. A non-write cycle retargets the RAM read register and is harmless.
- Priority pointer `prio` (0/1):
  - Both `req` in IDLE: grant `prio`.
  - Single `req`: grant it.
  - After any IDLE grant, `prio` ← other requester.
- FSM states:
  - IDLE to OWNx at the clock edge when x is granted with `lock_x` = 1 and `max_burst` > 1. Beat count ← 1.
  - OWNx: only x may be granted, and `req_y` is ignored. Each granted beat increments the count.
  - OWNx to IDLE, with `prio` ← y, at the edge of any cycle where `lock_x` = 0 (granted or not), or of the granted beat that makes count = `max_burst`.
  - OWNx with `req_x` = 0 and `lock_x` = 1: no grant, stay OWNx. The count does not change.
- Reads: a granted read sets `rvalid_x` at the next edge. In that cycle `rdata_x` = RAM content at the granted address.
- Back-to-back reads: each is valid exactly one cycle after its grant. A write then a read to the same address returns the new data.

## Timing
- Grant latency: 0 cycles. Write visible in RAM: after the grant-cycle edge. Read data: grant cycle + 1.
- Reset values: `gnt*` 0 (no req during reset assumed irrelevant; outputs forced 0 while `rst_n` = 0), `rvalid*` 0, `rdata*` 0, `ram_en` 0, state IDLE, `prio` 0, count 0.
- Reset asserted mid-burst or with a read in flight: the in-flight `rvalid` is dropped, and no `rvalid` follows deassertion.
- Simultaneous lock-exit and other-requester request: the other requester is granted no earlier than the cycle after the exit edge.
- Count width is `$clog2(max_burst+1)`. No wrap, because exit occurs at `max_burst`.

## Structure
- Package `ram_arb_pkg`: state enum {IDLE, OWN0, OWN1}, requester ID constants REQ0 = 0 and REQ1 = 1.
- Sub-module `rr_pick2`: combinational two-way round-robin pick from (`req0`, `req1`, `prio`) giving a one-hot grant.
- The top holds the FSM, burst counter, `prio` register, `rvalid` registers and muxes.

## Test plan
- Reset: hold `rst_n` = 0 with both `req` = 1. All outputs are 0. After release, the first contention grants req0.
- Write/read: req0 writes 0xA5 @0x10 (cycle N, `gnt0` = 1), then reads @0x10 at N+1. `rvalid0` = 1 and `rdata0` = 0xA5 at N+2, and `rvalid1` stays 0.
- Contention: both request every cycle with no lock. Grants alternate 0, 1, 0, 1. Read returns are routed only to the granted requester.
- Locked burst: req0 has `lock0` = 1 continuously and req1 is pending. `gnt0` occurs for exactly 4 consecutive beats, then `gnt1` on the next cycle.
- Early unlock: req0 locks for 2 beats then drops `lock0` with `req0` = 0. The FSM returns to IDLE at that edge, and `gnt1` follows the next cycle.
- Reset mid-read: a read is granted at cycle N and `rst_n` is pulsed low before N+1's edge. `rvalid0` never asserts, and the state is IDLE.
